imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; SHALL accept only 32 or 64.
REQ-002 Parameter STAGES, default 1, pipeline depth in registers; SHALL accept 1..4.
REQ-003 Parameter TAG_W, default 32, width of the sideband tag (PC or ROB id) carried alongside each instruction.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_inst, in_src and in_tag are valid.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_inst  input  32  full RV instruction word.
REQ-009 in_src  input  3  immediate type select.
REQ-010 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 flush  input  1  synchronous kill of all in-flight entries.
REQ-012 out_valid  output  1  out_imm, out_tag and out_err are valid.
REQ-013 out_ready  input  1  consumer accepts output.
REQ-014 out_imm  output  XLEN  extended immediate.
REQ-015 out_tag  output  TAG_W  tag of the emitted entry.
REQ-016 out_err  output  1  in_src was illegal for the emitted entry.

Function
REQ-017 Decode SHALL use these encodings: 000 I = inst[31:20]; 001 S = {inst[31:25],inst[11:7]}; 010 B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; 011 J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; 100 U = {inst[31:12],12'b0}.
REQ-018 Types I, S, B, J and U SHALL be sign-extended from their MSB to XLEN; U SHALL be sign-extended from inst[31] when XLEN=64.
REQ-019 101 SHAMT: SHALL zero-extend inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
REQ-020 110 ZIMM: SHALL zero-extend inst[19:15] (CSR immediate).
REQ-021 111 illegal: SHALL output out_imm=0 and out_err=1; all other codes SHALL output out_err=0.
REQ-022 Decode SHALL be combinational ahead of stage 1; stages 2..STAGES SHALL be pure register slices of {valid, imm, tag, err}.
REQ-023 A global advance SHALL be defined as adv = !out_valid || out_ready; every stage SHALL load from its predecessor only when adv=1.
REQ-024 in_ready SHALL equal adv; an input SHALL be accepted when in_valid && in_ready.
REQ-025 Latency from accepted input to out_valid SHALL be exactly STAGES cycles with no stall; throughput SHALL be one entry per cycle.
REQ-026 When out_ready=0 and out_valid=1, all stage registers SHALL hold; no entry SHALL be lost, duplicated or reordered.
REQ-027 Bubbles SHALL propagate as valid=0 slots; bubbles are not collapsed.
REQ-028 flush=1 SHALL clear every stage valid at the next edge, overriding adv, and SHALL drop any input presented that cycle; out_valid SHALL be 0 in the following cycle.
REQ-029 out_imm, out_tag and out_err SHALL be driven by the final stage registers with no combinational path from in_* to out_*.

Reset
REQ-030 Asserting rst SHALL immediately clear all stage valid bits, so out_valid=0 and in_ready=1.
REQ-031 On reset, out_imm SHALL be 0, out_tag SHALL be 0 and out_err SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries, and the first input accepted after release SHALL emerge after STAGES cycles.

Structure
REQ-033 Package imm_pkg SHALL hold the in_src enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_ILL) and the stage-payload struct.
REQ-034 The combinational decoder SHALL be the sub-module imm_decode (parameter XLEN; ports inst, src, imm, err); the pipeline SHALL be generated around it.

Verification
REQ-035 The bench SHALL check: STAGES=1, XLEN=32, in_inst=32'hFFF00093, src=I -> out_imm=32'hFFFFFFFF, out_err=0 one cycle later.
REQ-036 The bench SHALL check: in_inst=32'hFE000EE3, src=B -> out_imm=32'hFFFFFFFC; in_inst=32'h0080006F, src=J -> out_imm=32'h00000008.
REQ-037 The bench SHALL check: XLEN=64, in_inst=32'h800000B7, src=U -> out_imm=64'hFFFFFFFF80000000; src=SHAMT with inst[25:20]=6'h3F -> out_imm=64'h3F.
REQ-038 The bench SHALL check: STAGES=3, stream tags 1..6 back-to-back with out_ready held 0 for 4 cycles mid-stream -> in_ready drops, outputs emerge as tags 1..6 in order, each exactly once.
REQ-039 The bench SHALL check: src=3'b111 -> out_imm=0, out_err=1; flush with 2 entries in flight -> out_valid=0 on the next cycle and neither tag ever appears.
REQ-040 The bench SHALL check: rst asserted asynchronously between clock edges with entries in flight -> out_valid falls immediately; after release, a new entry emerges after STAGES cycles.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared types for the immediate-extension pipeline.
//   - imm_src_e   : immediate type select carried on in_src
//   - imm_stage_t : per-stage control payload (valid + illegal-select flag).
//                   The immediate and tag travel in parallel per-stage arrays
//                   because their widths are set by the XLEN/TAG_W parameters.
package imm_pkg;

    localparam int INST_W = 32;
    localparam int SRC_W  = 3;

    typedef enum logic [SRC_W-1:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    typedef struct packed {
        logic valid;
        logic err;
    } imm_stage_t;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
//   Combinational RV immediate extractor.
//   Ports:
//     inst : 32-bit instruction word
//     src  : immediate type select
//     imm  : extended immediate, XLEN bits
//     err  : high when src selects the illegal encoding (imm forced to 0)
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    input  imm_src_e          src,
    output logic [XLEN-1:0]   imm,
    output logic              err
);

    // Every immediate fits in 32 bits; build it there first, then widen
    // either signed or unsigned to XLEN.
    logic [31:0] raw;
    logic        sext;

    // The opcode field plays no part: the type comes from src.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    always_comb begin
        raw  = '0;
        sext = 1'b1;
        err  = 1'b0;
        case (src)
            IMM_I: raw = {{20{inst[31]}}, inst[31:20]};
            IMM_S: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U: raw = {inst[31:12], 12'b0};
            IMM_SHAMT: begin
                sext = 1'b0;
                if (XLEN == 64) begin
                    raw = {26'b0, inst[25:20]};
                end else begin
                    raw = {27'b0, inst[24:20]};
                end
            end
            IMM_ZIMM: begin
                sext = 1'b0;
                raw  = {27'b0, inst[19:15]};
            end
            IMM_ILL: begin
                sext = 1'b0;
                err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (sext) begin
            imm = XLEN'($signed(raw));
        end else begin
            imm = XLEN'(raw);
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decodes an RV immediate and carries it, with a sideband tag, through
//   STAGES register slices using valid/ready handshaking.
//   Ports:
//     clk, rst                     : clock, async active-high reset
//     in_valid/in_ready            : input handshake
//     in_inst, in_src, in_tag      : instruction, immediate type, sideband tag
//     flush                        : synchronous kill of all in-flight entries
//     out_valid/out_ready          : output handshake
//     out_imm, out_tag, out_err    : final-stage payload
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [SRC_W-1:0]  in_src,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("imm_extend_pipe: STAGES must be 1..4");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst (in_inst),
        .src  (imm_src_e'(in_src)),
        .imm  (dec_imm),
        .err  (dec_err)
    );

    imm_stage_t       flags_q [STAGES];
    logic [XLEN-1:0]  imm_q   [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];

    // One global advance: the whole pipe moves together, so a stall at the
    // output freezes every slice and bubbles are kept in place.
    logic adv;
    assign adv      = !flags_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        imm_stage_t       flags_d;
        logic [XLEN-1:0]  imm_d;
        logic [TAG_W-1:0] tag_d;

        if (s == 0) begin : g_head
            assign flags_d = '{valid: in_valid, err: dec_err};
            assign imm_d   = dec_imm;
            assign tag_d   = in_tag;
        end else begin : g_body
            assign flags_d = flags_q[s-1];
            assign imm_d   = imm_q[s-1];
            assign tag_d   = tag_q[s-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                flags_q[s] <= '0;
                imm_q[s]   <= '0;
                tag_q[s]   <= '0;
            end else if (flush) begin
                // Only the valid bits matter; stale payload is harmless.
                flags_q[s].valid <= 1'b0;
            end else if (adv) begin
                flags_q[s] <= flags_d;
                imm_q[s]   <= imm_d;
                tag_q[s]   <= tag_d;
            end
        end
    end

    assign out_valid = flags_q[STAGES-1].valid;
    assign out_err   = flags_q[STAGES-1].err;
    assign out_imm   = imm_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_inst;
    logic [2:0]  in_src;
    logic [31:0] in_tag;

    // u_a: XLEN=32 STAGES=1, u_b: XLEN=64 STAGES=2, u_c: XLEN=32 STAGES=3
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_out_imm, a_out_tag;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_err;
    logic [63:0] b_out_imm;
    logic [31:0] b_out_tag;
    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_out_err;
    logic [31:0] c_out_imm, c_out_tag;

    imm_extend_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_src(in_src), .in_tag(in_tag), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_err(a_out_err)
    );
    imm_extend_pipe #(.XLEN(64), .STAGES(2), .TAG_W(32)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_src(in_src), .in_tag(in_tag), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );
    imm_extend_pipe #(.XLEN(32), .STAGES(3), .TAG_W(32)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_src(in_src), .in_tag(in_tag), .flush(c_flush),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_imm(c_out_imm),
        .out_tag(c_out_tag), .out_err(c_out_err)
    );

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int total = 0;
    int bad   = 0;

    localparam int N32 = 10;
    localparam logic [31:0] T32_INST [N32] = '{
        32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'hFE112E23, 32'h02112423,
        32'h800000B7, 32'h03F00013, 32'h000F8073, 32'hFFFFFFFF, 32'h7FF00093};
    localparam logic [2:0] T32_SRC [N32] = '{
        3'd0, 3'd2, 3'd3, 3'd1, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    localparam logic [31:0] T32_IMM [N32] = '{
        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h00000028,
        32'h80000000, 32'h0000001F, 32'h0000001F, 32'h00000000, 32'h000007FF};
    localparam logic T32_ERR [N32] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    localparam int N64 = 8;
    localparam logic [31:0] T64_INST [N64] = '{
        32'h800000B7, 32'h03F00013, 32'hFFF00093, 32'h0080006F,
        32'h000F8073, 32'h12345037, 32'h800000B7, 32'hFE000EE3};
    localparam logic [2:0] T64_SRC [N64] = '{
        3'd4, 3'd5, 3'd0, 3'd3, 3'd6, 3'd4, 3'd7, 3'd2};
    localparam logic [63:0] T64_IMM [N64] = '{
        64'hFFFFFFFF80000000, 64'h000000000000003F, 64'hFFFFFFFFFFFFFFFF,
        64'h0000000000000008, 64'h000000000000001F, 64'h0000000012345000,
        64'h0000000000000000, 64'hFFFFFFFFFFFFFFFC};
    localparam logic T64_ERR [N64] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_a_hs out_valid=%b in_ready=%b required 0/1", a_out_valid, a_in_ready);
        end
        total++;
        if (a_out_imm !== 32'h0 || a_out_tag !== 32'h0 || a_out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_a_data imm=%h tag=%h err=%b required 0/0/0", a_out_imm, a_out_tag, a_out_err);
        end
        total++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_imm !== 64'h0 ||
            b_out_tag !== 32'h0 || b_out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_b v=%b rdy=%b imm=%h tag=%h err=%b required 0/1/0/0/0",
                     b_out_valid, b_in_ready, b_out_imm, b_out_tag, b_out_err);
        end
        total++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_out_imm !== 32'h0 ||
            c_out_tag !== 32'h0 || c_out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_c v=%b rdy=%b imm=%h tag=%h err=%b required 0/1/0/0/0",
                     c_out_valid, c_in_ready, c_out_imm, c_out_tag, c_out_err);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_decode_x32();
        exp_t e;
        int   sent = 0;
        int   got = 0;
        int   first_cyc = -1;
        int   last_cyc = -1;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < N32; cyc++) begin
            if (sent < N32) begin
                a_in_valid = 1'b1;
                in_inst    = T32_INST[sent];
                in_src     = T32_SRC[sent];
                in_tag     = 32'hA000_0000 + 32'(sent);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (a_out_valid && a_out_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                total++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("FAIL decode32_extra tag=%h required no output", a_out_tag);
                end else begin
                    e = q_a.pop_front();
                    if (a_out_imm !== e.imm[31:0] || a_out_err !== e.err || a_out_tag !== e.tag) begin
                        bad++;
                        $display("FAIL decode32 imm=%h err=%b tag=%h required imm=%h err=%b tag=%h",
                                 a_out_imm, a_out_err, a_out_tag, e.imm[31:0], e.err, e.tag);
                    end
                end
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                q_a.push_back('{imm: {32'h0, T32_IMM[sent]}, tag: in_tag, err: T32_ERR[sent]});
                sent++;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        total++;
        if (got != N32) begin
            bad++;
            $display("FAIL decode32_count got=%0d required %0d", got, N32);
        end
        total++;
        if (first_cyc != 1) begin
            bad++;
            $display("FAIL decode32_latency cycles=%0d required 1", first_cyc);
        end
        total++;
        if (last_cyc != N32) begin
            bad++;
            $display("FAIL decode32_throughput last=%0d required %0d", last_cyc, N32);
        end
    endtask

    task automatic test_decode_x64();
        exp_t e;
        int   sent = 0;
        int   got = 0;
        int   first_cyc = -1;
        int   last_cyc = -1;
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < N64; cyc++) begin
            // cycle 3 is a deliberate bubble
            if (sent < N64 && cyc != 3) begin
                b_in_valid = 1'b1;
                in_inst    = T64_INST[sent];
                in_src     = T64_SRC[sent];
                in_tag     = 32'hB000_0000 + 32'(sent);
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            if (cyc == 5) begin
                total++;
                if (b_out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL decode64_bubble out_valid=%b required 0", b_out_valid);
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                total++;
                if (q_b.size() == 0) begin
                    bad++;
                    $display("FAIL decode64_extra tag=%h required no output", b_out_tag);
                end else begin
                    e = q_b.pop_front();
                    if (b_out_imm !== e.imm || b_out_err !== e.err || b_out_tag !== e.tag) begin
                        bad++;
                        $display("FAIL decode64 imm=%h err=%b tag=%h required imm=%h err=%b tag=%h",
                                 b_out_imm, b_out_err, b_out_tag, e.imm, e.err, e.tag);
                    end
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                q_b.push_back('{imm: T64_IMM[sent], tag: in_tag, err: T64_ERR[sent]});
                sent++;
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        total++;
        if (got != N64) begin
            bad++;
            $display("FAIL decode64_count got=%0d required %0d", got, N64);
        end
        total++;
        if (first_cyc != 2) begin
            bad++;
            $display("FAIL decode64_latency cycles=%0d required 2", first_cyc);
        end
        total++;
        if (last_cyc != N64 + 2) begin
            bad++;
            $display("FAIL decode64_last last=%0d required %0d", last_cyc, N64 + 2);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   next_tag = 1;
        int   got = 0;
        logic saw_stall = 1'b0;
        logic rdy_bad = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            c_out_ready = !(cyc >= 4 && cyc < 8);
            if (next_tag <= 6) begin
                c_in_valid = 1'b1;
                in_tag     = 32'(next_tag);
                in_inst    = {12'(next_tag), 20'h00093};
                in_src     = 3'd0;
            end else begin
                c_in_valid = 1'b0;
            end
            #1;
            if (c_in_valid && !c_in_ready) saw_stall = 1'b1;
            if (c_in_ready !== (!c_out_valid || c_out_ready)) rdy_bad = 1'b1;
            if (c_out_valid && c_out_ready) begin
                total++;
                if (q_c.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra tag=%h required no output", c_out_tag);
                end else begin
                    e = q_c.pop_front();
                    if (c_out_tag !== e.tag || c_out_imm !== e.imm[31:0] || c_out_err !== e.err) begin
                        bad++;
                        $display("FAIL b2b_order tag=%h imm=%h err=%b required tag=%h imm=%h err=%b",
                                 c_out_tag, c_out_imm, c_out_err, e.tag, e.imm[31:0], e.err);
                    end
                end
                got++;
            end
            if (c_in_valid && c_in_ready) begin
                q_c.push_back('{imm: 64'(next_tag), tag: in_tag, err: 1'b0});
                next_tag++;
            end
            @(posedge clk); #1;
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        total++;
        if (!saw_stall) begin
            bad++;
            $display("FAIL b2b_in_ready_drop seen=%b required 1", saw_stall);
        end
        total++;
        if (rdy_bad) begin
            bad++;
            $display("FAIL b2b_in_ready_rule violated=%b required 0", rdy_bad);
        end
        total++;
        if (got != 6) begin
            bad++;
            $display("FAIL b2b_count got=%0d required 6", got);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (c_out_valid) got++;
        end
        total++;
        if (got != 6) begin
            bad++;
            $display("FAIL b2b_duplicate outputs=%0d required 6", got);
        end
    endtask

    task automatic test_flush();
        logic ghost = 1'b0;
        int   lat = -1;
        @(posedge clk); #1;
        c_out_ready = 1'b1;
        in_src      = 3'd0;
        c_in_valid = 1'b1; in_tag = 32'h11; in_inst = 32'h01100093;
        @(posedge clk); #1;
        c_in_valid = 1'b1; in_tag = 32'h22; in_inst = 32'h02200093;
        @(posedge clk); #1;
        c_in_valid = 1'b1; in_tag = 32'h33; in_inst = 32'h03300093;
        c_flush    = 1'b1;
        @(posedge clk); #1;
        c_flush    = 1'b0;
        c_in_valid = 1'b0;
        q_c.delete();
        total++;
        if (c_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_next out_valid=%b required 0", c_out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (c_out_valid) ghost = 1'b1;
        end
        total++;
        if (ghost) begin
            bad++;
            $display("FAIL flush_ghost flushed tag seen=%b required 0", ghost);
        end
        c_in_valid = 1'b1; in_tag = 32'h44; in_inst = 32'h04400093;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            if (c_out_valid) lat = i;
            else begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (lat != 3 || c_out_tag !== 32'h44 || c_out_imm !== 32'h44) begin
            bad++;
            $display("FAIL flush_recover lat=%0d tag=%h imm=%h required 3/44/44", lat, c_out_tag, c_out_imm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat = -1;
        @(posedge clk); #1;
        c_out_ready = 1'b0;
        in_src      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            c_in_valid = 1'b1;
            in_tag     = 32'h51 + 32'(i);
            in_inst    = 32'h05100093;
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        total++;
        if (c_out_valid !== 1'b1 || c_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_pre out_valid=%b in_ready=%b required 1/0", c_out_valid, c_in_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_out_tag !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async out_valid=%b in_ready=%b tag=%h required 0/1/0",
                     c_out_valid, c_in_ready, c_out_tag);
        end
        #2;
        rst = 1'b0;
        q_c.delete();
        @(posedge clk); #1;
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        in_tag      = 32'h66;
        in_inst     = 32'h06600093;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            if (c_out_valid) lat = i;
            else begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (lat != 3 || c_out_tag !== 32'h66 || c_out_imm !== 32'h66) begin
            bad++;
            $display("FAIL rstmid_after lat=%0d tag=%h imm=%h required 3/66/66", lat, c_out_tag, c_out_imm);
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b1;
        in_inst = '0; in_src = '0; in_tag = '0;
        test_reset();
        test_decode_x32();
        test_decode_x64();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
